// File: rtl/rsa_pubkey_gen.sv
// RSA public-key producer: n = p*q, totient = (p-1)(q-1), smallest odd e coprime to totient.
// Optional RSA_PUBKEY_F4_EN: when totient > 65537, try e = 65537 before the normal search.
module rsa_pubkey_gen #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned PRIME_W = 12,
    parameter int unsigned E_START = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PRIME_W-1:0] p,
    input  logic [PRIME_W-1:0] q,
    output logic [WIDTH-1:0]   n,
    output logic [WIDTH-1:0]   totient,
    output logic [WIDTH-1:0]   e,
    output logic               busy,
    output logic               done,
    output logic               error
);
    // Candidate carries one extra bit so the +2 step can never wrap.
    localparam int unsigned CW   = WIDTH + 1;
    localparam int unsigned F4_E = 65537;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_SEED, S_GCD, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [PRIME_W-1:0] p_q, p_d, q_q, q_d;
    logic [WIDTH-1:0]   n_q, n_d, tot_q, tot_d, e_q, e_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CW-1:0]      cand_q, cand_d;
    logic               busy_q, busy_d, done_q, done_d, error_q, error_d;
`ifdef RSA_PUBKEY_F4_EN
    logic               f4_q, f4_d;
`endif

    logic [WIDTH-1:0] n_calc_c, tot_calc_c;
    logic [CW-1:0]    cand_nxt_c;

    assign n_calc_c   = WIDTH'(p_q) * WIDTH'(q_q);
    assign tot_calc_c = WIDTH'(p_q - PRIME_W'(1)) * WIDTH'(q_q - PRIME_W'(1));
    assign cand_nxt_c = cand_q + CW'(2);

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        n_d     = n_q;
        tot_d   = tot_q;
        e_d     = e_q;
        a_d     = a_q;
        b_d     = b_q;
        cand_d  = cand_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
`ifdef RSA_PUBKEY_F4_EN
        f4_d    = f4_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    p_d     = p;
                    q_d     = q;
                    e_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (p_q < PRIME_W'(2) || q_q < PRIME_W'(2)) begin
                    n_d     = '0;
                    tot_d   = '0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    n_d   = n_calc_c;
                    tot_d = tot_calc_c;
                    if (tot_calc_c <= WIDTH'(E_START)) begin
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        cand_d  = CW'(E_START);
`ifdef RSA_PUBKEY_F4_EN
                        f4_d    = 1'b0;
                        if (tot_calc_c > WIDTH'(F4_E)) begin
                            cand_d = CW'(F4_E);
                            f4_d   = 1'b1;
                        end
`endif
                        state_d = S_SEED;
                    end
                end
            end
            S_SEED: begin
                a_d     = tot_q;
                b_d     = cand_q[WIDTH-1:0];
                state_d = S_GCD;
            end
            S_GCD: begin
                if (b_q != '0) begin
                    a_d = b_q;
                    b_d = a_q % b_q;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (a_q == WIDTH'(1)) begin
                    e_d     = cand_q[WIDTH-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
`ifdef RSA_PUBKEY_F4_EN
                    // 65537 shared a factor with the totient: restart the ordinary search.
                    if (f4_q) begin
                        f4_d    = 1'b0;
                        cand_d  = CW'(E_START);
                        state_d = S_SEED;
                    end else
`endif
                    begin
                        cand_d = cand_nxt_c;
                        if (cand_nxt_c >= CW'(tot_q)) begin
                            e_d     = '0;
                            busy_d  = 1'b0;
                            error_d = 1'b1;
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_SEED;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            q_q     <= '0;
            n_q     <= '0;
            tot_q   <= '0;
            e_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cand_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef RSA_PUBKEY_F4_EN
            f4_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            n_q     <= n_d;
            tot_q   <= tot_d;
            e_q     <= e_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cand_q  <= cand_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef RSA_PUBKEY_F4_EN
            f4_q    <= f4_d;
`endif
        end
    end

    assign n       = n_q;
    assign totient = tot_q;
    assign e       = e_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_rsa_pubkey_gen.sv
// Randomised self-checking bench for rsa_pubkey_gen against an arithmetic key-generation model.
`timescale 1ns/1ps
module tb_rsa_pubkey_gen;
    localparam int unsigned WIDTH   = 24;
    localparam int unsigned PRIME_W = 12;
    localparam int unsigned E_START = 3;
    localparam int          BUDGET  = 4000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [PRIME_W-1:0] p = '0;
    logic [PRIME_W-1:0] q = '0;
    logic [WIDTH-1:0]   n, totient, e;
    logic               busy, done, error;

    rsa_pubkey_gen #(.WIDTH(WIDTH), .PRIME_W(PRIME_W), .E_START(E_START)) dut (
        .clk(clk), .rst(rst), .start(start), .p(p), .q(q),
        .n(n), .totient(totient), .e(e), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    bit     armed = 1'b0;
    bit     rst_chk = 1'b0;
    int     epoch = 0;
    longint exp_n = 0, exp_t = 0, exp_e = 0;
    bit     exp_err = 1'b0;

    bit     pinned = 1'b0;
    bit     settled = 1'b0;
    int     seen_epoch = 0;
    int     cyc = 0;

    function automatic longint gcd(input longint a, input longint b);
        longint t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Key generation straight from the arithmetic definition.
    task automatic model(input int pp, input int qq,
                         output longint mn, output longint mt, output longint me, output bit merr);
        mn = 0; mt = 0; me = 0; merr = 1'b1;
        if (pp < 2 || qq < 2) return;
        mn = longint'(pp) * longint'(qq);
        mt = longint'(pp - 1) * longint'(qq - 1);
        if (mt <= longint'(E_START)) return;
`ifdef RSA_PUBKEY_F4_EN
        if (mt > 65537 && gcd(65537, mt) == 1) begin
            me = 65537; merr = 1'b0; return;
        end
`endif
        for (longint c = longint'(E_START); c < mt; c += 2) begin
            if (gcd(c, mt) == 1) begin
                me = c; merr = 1'b0; return;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, expv);
        end
    endtask

    // Single compare process: model pins once, then outputs on every meaningful cycle.
    always @(negedge clk) begin
        longint mn, mt, me;
        bit     merr;
        if (!pinned) begin
            pinned = 1'b1;
            model(61, 53, mn, mt, me, merr);
            chk("pin61_n", mn, 3233); chk("pin61_t", mt, 3120); chk("pin61_e", me, 7); chk("pin61_err", merr, 0);
            model(3, 11, mn, mt, me, merr);
            chk("pin3_n", mn, 33); chk("pin3_t", mt, 20); chk("pin3_e", me, 3);
            model(4093, 4091, mn, mt, me, merr);
            chk("pin4093_n", mn, 16744463); chk("pin4093_t", mt, 16736280);
`ifdef RSA_PUBKEY_F4_EN
            chk("pin4093_e", me, 65537);
`else
            chk("pin4093_e", me, 7);
`endif
            model(1, 5, mn, mt, me, merr);
            chk("pin1_err", merr, 1); chk("pin1_n", mn, 0);
            model(2, 3, mn, mt, me, merr);
            chk("pin2_err", merr, 1); chk("pin2_n", mn, 6); chk("pin2_t", mt, 2);
        end
        if (rst_chk) begin
            chk("rst_n", n, 0); chk("rst_totient", totient, 0); chk("rst_e", e, 0);
            chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_error", error, 0);
        end else if (armed) begin
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                settled = 1'b0;
                cyc = 0;
            end
            if (!settled) begin
                if (done || error) begin
                    chk("res_n", n, exp_n); chk("res_totient", totient, exp_t); chk("res_e", e, exp_e);
                    chk("res_done", done, !exp_err); chk("res_error", error, exp_err); chk("res_busy", busy, 0);
                    settled = 1'b1;
                end else begin
                    chk("run_busy", busy, 1);
                    cyc++;
                    if (cyc > BUDGET) begin
                        checks++; failures++;
                        $display("FAIL timeout cycles=%0d limit=%0d", cyc, BUDGET);
                        settled = 1'b1;
                    end
                end
            end else begin
                chk("hold_n", n, exp_n); chk("hold_e", e, exp_e);
                chk("hold_done", done, !exp_err); chk("hold_error", error, exp_err); chk("hold_busy", busy, 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        armed = 1'b0;
        @(posedge clk);
        #1 rst_chk = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rst_chk = 1'b0;
    endtask

    task automatic launch(input int pp, input int qq);
        longint mn, mt, me;
        bit     merr;
        model(pp, qq, mn, mt, me, merr);
        @(negedge clk);
        p = PRIME_W'(pp);
        q = PRIME_W'(qq);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        exp_n = mn; exp_t = mt; exp_e = me; exp_err = merr;
        epoch++;
        armed = 1'b1;
        p = PRIME_W'($urandom);
        q = PRIME_W'($urandom);
    endtask

    task automatic finish_run();
        int k = 0;
        while (!(done || error) && k < BUDGET + 20) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int pp, qq;
        do_reset();
        launch(61, 53);
        repeat (3) @(posedge clk);
        @(negedge clk);
        p = PRIME_W'(7); q = PRIME_W'(5); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_run();
        launch(3, 11);    finish_run();
        launch(4093, 4091); finish_run();
        launch(1, 5);     finish_run();
        launch(2, 3);     finish_run();
        launch(4093, 4091);
        repeat (3) @(posedge clk);
        do_reset();
        launch(61, 53);   finish_run();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                pp = int'($urandom_range(0, 24));
                qq = int'($urandom_range(0, 24));
            end else begin
                pp = int'($urandom_range(0, 4095));
                qq = int'($urandom_range(0, 4095));
            end
            launch(pp, qq);
            finish_run();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog elapsed");
        $fatal(1);
    end
endmodule
